l1_mem_arbiter: RTL and testbench
=================================

# l1_mem_arbiter

Two-port arbiter that shares the single memory/AXI-bridge port between the L1 Icache miss path and the L1 Dcache miss/write path. It sits between both caches' `*_mem_*` ports and the memory side, grants one requester at a time with round-robin fairness, latches the winner's request, and routes `dataOK` and line data back only to the owner. The Icache side needs no changes: its `req` / `addr` / `SUC` / `size` / `dataOK` protocol is unchanged.

## Interface
Parameters:
- `offset_width`, 2, log2 of words per line; line width `LW = 32*(1<<offset_width)`.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `icache_mem_req` in 1: Icache request, level, held until its `dataOK`.
- `addr_icache_mem` in 32: Icache physical address.
- `icache_mem_SUC` in 1: strongly-uncached access.
- `icache_mem_size` in 2: access size (0=1B, 1=2B, 2=4B).
- `mem_icache_dataOK` out 1: one-cycle completion pulse to Icache.
- `din_mem_icache` out LW: read line to Icache, valid while `mem_icache_dataOK` is high.
- `dcache_mem_req` in 1: Dcache request, level, held until its `dataOK`.
- `dcache_mem_we` in 1: 1 = write, 0 = read.
- `addr_dcache_mem` in 32: Dcache physical address.
- `dcache_mem_SUC` in 1: strongly-uncached access.
- `dcache_mem_size` in 2: access size.
- `dout_dcache_mem` in LW: write data.
- `mem_dcache_dataOK` out 1: completion pulse to Dcache.
- `din_mem_dcache` out LW: read line to Dcache.
- `arb_mem_req` out 1: request to memory, held until `mem_arb_dataOK`.
- `arb_mem_we` out 1: latched write flag.
- `arb_mem_addr` out 32: latched address.
- `arb_mem_SUC` out 1: latched SUC flag.
- `arb_mem_size` out 2: latched size.
- `arb_mem_wdata` out LW: latched write data.
- `mem_arb_dataOK` in 1: memory completion pulse.
- `mem_arb_rdata` in LW: memory read line.

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`.
- **Grant in `IDLE`:**
  - Eligible requesters are those with `req` high and not masked.
  - Exactly one eligible: grant it.
  - Both eligible: grant the one not in `last_grant`.
  - On grant, latch `addr`/`we`/`SUC`/`size`/`wdata` into the request buffer. The Icache grant forces `we=0` and `wdata=0`.
  - Set `last_grant` to the winner and move to `BUSY_I` or `BUSY_D`.
- **`BUSY_x`:**
  - `arb_mem_req`=1 and all `arb_mem_*` outputs are driven from the buffer; they stay stable regardless of requester inputs.
  - When `mem_arb_dataOK`=1:
    - forward the pulse combinationally to owner `x` only;
    - pass `mem_arb_rdata` through to `din_mem_x`;
    - go to `IDLE`;
    - set `served_mask` = {x}.
- **`served_mask`:** masks requester x from arbitration for the first `IDLE` cycle only, then clears. This covers requesters whose `req` falls one cycle late.
- **Non-owner outputs:** the non-owner's `dataOK` is always 0. Its `din` is 0 whenever its `dataOK` is 0.
- **Unexpected `dataOK`:** `mem_arb_dataOK` in `IDLE` is ignored and not forwarded.
- **Requester contract:** no abort. Once `req` is raised it stays high until that requester's `dataOK`.

## Timing
- **Reset values:** state=`IDLE`, `last_grant`=D (so Icache wins the first tie), `served_mask`=0, all `arb_mem_*`=0, both `dataOK`=0, both `din`=0.
- **Grant latency:** requester `req` seen in `IDLE` at cycle t gives `arb_mem_req`=1 at t+1.
- **Completion:** `dataOK` to the owner is in the same cycle as `mem_arb_dataOK` (zero added latency).
- **Turnaround:** dataOK at t, then `IDLE` at t+1. A pending other requester is granted at t+1, so `arb_mem_req` is high again at t+2. Minimum one idle memory cycle between transactions.
- **Simultaneous events:**
  - both `req` rise in the same cycle: round-robin tie-break as above;
  - `req` rising during `BUSY`: waits, with no loss;
  - `rst` high during `BUSY`: next cycle is `IDLE` with reset values, and the pending transaction is dropped. The memory side is reset by the same `rst`.
- **Widths:** all buffer fields match port widths exactly. No arithmetic.

## Structure
- Package `l1_mem_arb_pkg`:
  - `arb_state_t` enum (`IDLE`/`BUSY_I`/`BUSY_D`);
  - `owner_t` (I=0, D=1);
  - `mem_req_t` struct (`addr`, `we`, `SUC`, `size`, `wdata`) parameterised on LW via a localparam of `offset_width`.
- Sub-module `l1_mem_arb_rr`: 2-way round-robin picker. Inputs are the eligible vector and `last_grant`; outputs are `grant_valid` and `grant_id`. The FSM, request buffer and return mux stay in the top module.

## Test plan
- **Reset, then single Icache request.** Icache `req`, addr 0x1C000040, at cycle 5; memory dataOK at cycle 9 with rdata 0xA5.. → `arb_mem_req`=1 from 6 to 9, `arb_mem_addr`=0x1C000040, `we`=0, `mem_icache_dataOK`=1 only at 9, Dcache sees nothing.
- **Simultaneous requests after reset.** Both requests at cycle 3 → Icache is served first. Dcache (`we`=1, addr 0x00001000, wdata pattern) is granted at dataOK+1 with `arb_mem_we`=1 and the exact wdata. A third tie then goes to Icache.
- **Late `req` drop.** Icache holds `req` one cycle past its `dataOK` while Dcache is idle → no second Icache grant occurs. `arb_mem_req` stays 0.
- **Input change while busy.** Dcache changes addr/wdata while `BUSY_D` → `arb_mem_*` unchanged until dataOK.
- **Reset mid-transaction.** `rst` asserted in `BUSY_I` → next cycle all outputs are 0 and state is `IDLE`. A subsequent Dcache request is granted normally.
- **Stray completion.** `mem_arb_dataOK` pulsed in `IDLE` → both cache `dataOK` stay 0.

Source files
------------

// File: rtl/l1_mem_arb_pkg.sv
// Shared types for the L1 memory arbiter: FSM states, requester ids and
// the latched request buffer that drives the memory-side port.
package l1_mem_arb_pkg;

  // Default line geometry: 4 words per line, 128-bit lines.
  localparam int OFFSET_WIDTH = 2;
  localparam int LINE_W       = 32 * (1 << OFFSET_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic              SUC;
    logic [1:0]        size;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/l1_mem_arb_rr.sv
// Two-way round-robin picker: a lone eligible requester always wins,
// a tie goes to whichever requester did not win last time.
module l1_mem_arb_rr
  import l1_mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  owner_t     last_grant,
  output logic       grant_valid,
  output owner_t     grant_id
);

  // Pick the winner from the eligible vector (bit 0 = Icache, bit 1 = Dcache).
  always_comb begin
    grant_valid = |eligible;
    grant_id    = OWN_I;
    if (eligible == 2'b11) begin
      grant_id = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (eligible[1]) begin
      grant_id = OWN_D;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares the single memory port between the Icache miss path and the
// Dcache miss/write path. One owner at a time, round-robin on ties, the
// winner's request is latched so the memory side sees stable signals,
// and completion/read data is routed back to the owner only.
module l1_mem_arbiter
  import l1_mem_arb_pkg::*;
#(
  parameter int offset_width = OFFSET_WIDTH,
  localparam int LW = 32 * (1 << offset_width)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          icache_mem_req,
  input  logic [31:0]   addr_icache_mem,
  input  logic          icache_mem_SUC,
  input  logic [1:0]    icache_mem_size,
  output logic          mem_icache_dataOK,
  output logic [LW-1:0] din_mem_icache,

  input  logic          dcache_mem_req,
  input  logic          dcache_mem_we,
  input  logic [31:0]   addr_dcache_mem,
  input  logic          dcache_mem_SUC,
  input  logic [1:0]    dcache_mem_size,
  input  logic [LW-1:0] dout_dcache_mem,
  output logic          mem_dcache_dataOK,
  output logic [LW-1:0] din_mem_dcache,

  output logic          arb_mem_req,
  output logic          arb_mem_we,
  output logic [31:0]   arb_mem_addr,
  output logic          arb_mem_SUC,
  output logic [1:0]    arb_mem_size,
  output logic [LW-1:0] arb_mem_wdata,
  input  logic          mem_arb_dataOK,
  input  logic [LW-1:0] mem_arb_rdata
);

  arb_state_t state_q, state_d;
  owner_t     last_grant_q, last_grant_d;
  logic [1:0] served_mask_q, served_mask_d;
  mem_req_t   req_buf_q, req_buf_d;

  logic [1:0] eligible;
  logic       grant_valid;
  owner_t     grant_id;

  // A requester that just finished is held out of the first idle cycle so a
  // req that drops one cycle late does not trigger a phantom second grant.
  assign eligible = {dcache_mem_req & ~served_mask_q[1],
                     icache_mem_req & ~served_mask_q[0]};

  l1_mem_arb_rr u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // State, fairness history, served mask and request buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= OWN_D;
      served_mask_q <= 2'b00;
      req_buf_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      served_mask_q <= served_mask_d;
      req_buf_q     <= req_buf_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, wait for completion in BUSY.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    served_mask_d = 2'b00;
    req_buf_d     = req_buf_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          if (grant_id == OWN_I) begin
            state_d         = BUSY_I;
            req_buf_d.addr  = addr_icache_mem;
            req_buf_d.we    = 1'b0;
            req_buf_d.SUC   = icache_mem_SUC;
            req_buf_d.size  = icache_mem_size;
            req_buf_d.wdata = '0;
          end else begin
            state_d         = BUSY_D;
            req_buf_d.addr  = addr_dcache_mem;
            req_buf_d.we    = dcache_mem_we;
            req_buf_d.SUC   = dcache_mem_SUC;
            req_buf_d.size  = dcache_mem_size;
            req_buf_d.wdata = dout_dcache_mem;
          end
        end
      end
      BUSY_I: begin
        if (mem_arb_dataOK) begin
          state_d       = IDLE;
          served_mask_d = 2'b01;
        end
      end
      BUSY_D: begin
        if (mem_arb_dataOK) begin
          state_d       = IDLE;
          served_mask_d = 2'b10;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory side is driven straight from the buffer so it cannot glitch
  // when the caches change their inputs mid-transaction.
  assign arb_mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign arb_mem_we    = req_buf_q.we;
  assign arb_mem_addr  = req_buf_q.addr;
  assign arb_mem_SUC   = req_buf_q.SUC;
  assign arb_mem_size  = req_buf_q.size;
  assign arb_mem_wdata = req_buf_q.wdata;

  // Completion goes back only to the owner; a stray pulse in IDLE is dropped.
  assign mem_icache_dataOK = (state_q == BUSY_I) && mem_arb_dataOK;
  assign mem_dcache_dataOK = (state_q == BUSY_D) && mem_arb_dataOK;
  assign din_mem_icache    = mem_icache_dataOK ? mem_arb_rdata : '0;
  assign din_mem_dcache    = mem_dcache_dataOK ? mem_arb_rdata : '0;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter with hand-computed
// expectations for grant order, latching, routing and reset behaviour.
module tb_l1_mem_arbiter;

  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_mem_req;
  logic [31:0]   addr_icache_mem;
  logic          icache_mem_SUC;
  logic [1:0]    icache_mem_size;
  logic          mem_icache_dataOK;
  logic [LW-1:0] din_mem_icache;
  logic          dcache_mem_req;
  logic          dcache_mem_we;
  logic [31:0]   addr_dcache_mem;
  logic          dcache_mem_SUC;
  logic [1:0]    dcache_mem_size;
  logic [LW-1:0] dout_dcache_mem;
  logic          mem_dcache_dataOK;
  logic [LW-1:0] din_mem_dcache;
  logic          arb_mem_req;
  logic          arb_mem_we;
  logic [31:0]   arb_mem_addr;
  logic          arb_mem_SUC;
  logic [1:0]    arb_mem_size;
  logic [LW-1:0] arb_mem_wdata;
  logic          mem_arb_dataOK;
  logic [LW-1:0] mem_arb_rdata;

  int compared = 0;
  int mismatched = 0;

  localparam logic [LW-1:0] RDATA_A5 = {4{32'hA5A5_A5A5}};
  localparam logic [LW-1:0] RDATA_3C = {4{32'h3C3C_3C3C}};
  localparam logic [LW-1:0] WDATA_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] WDATA_X  = {4{32'hDEAD_BEEF}};

  l1_mem_arbiter #(.offset_width(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_mem_req    (icache_mem_req),
    .addr_icache_mem   (addr_icache_mem),
    .icache_mem_SUC    (icache_mem_SUC),
    .icache_mem_size   (icache_mem_size),
    .mem_icache_dataOK (mem_icache_dataOK),
    .din_mem_icache    (din_mem_icache),
    .dcache_mem_req    (dcache_mem_req),
    .dcache_mem_we     (dcache_mem_we),
    .addr_dcache_mem   (addr_dcache_mem),
    .dcache_mem_SUC    (dcache_mem_SUC),
    .dcache_mem_size   (dcache_mem_size),
    .dout_dcache_mem   (dout_dcache_mem),
    .mem_dcache_dataOK (mem_dcache_dataOK),
    .din_mem_dcache    (din_mem_dcache),
    .arb_mem_req       (arb_mem_req),
    .arb_mem_we        (arb_mem_we),
    .arb_mem_addr      (arb_mem_addr),
    .arb_mem_SUC       (arb_mem_SUC),
    .arb_mem_size      (arb_mem_size),
    .arb_mem_wdata     (arb_mem_wdata),
    .mem_arb_dataOK    (mem_arb_dataOK),
    .mem_arb_rdata     (mem_arb_rdata)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [LW-1:0] obs,
                             input logic [LW-1:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances one cycle; inputs change and outputs are sampled 2 ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    icache_mem_req = 1'b0; addr_icache_mem = '0; icache_mem_SUC = 1'b0; icache_mem_size = 2'd0;
    dcache_mem_req = 1'b0; dcache_mem_we = 1'b0; addr_dcache_mem = '0;
    dcache_mem_SUC = 1'b0; dcache_mem_size = 2'd0; dout_dcache_mem = '0;
    mem_arb_dataOK = 1'b0; mem_arb_rdata = '0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("rst_req",   arb_mem_req, 0);
    checkOutput("rst_addr",  arb_mem_addr, 0);
    checkOutput("rst_wdata", arb_mem_wdata, 0);
    checkOutput("rst_iok",   mem_icache_dataOK, 0);
    checkOutput("rst_dok",   mem_dcache_dataOK, 0);

    // Single Icache request.
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_0040; icache_mem_size = 2'd2; icache_mem_SUC = 1'b1;
    #1 checkOutput("t1_req_idle", arb_mem_req, 0);
    applyStimulus();
    checkOutput("t1_req",  arb_mem_req, 1);
    checkOutput("t1_addr", arb_mem_addr, 32'h1C00_0040);
    checkOutput("t1_we",   arb_mem_we, 0);
    checkOutput("t1_size", arb_mem_size, 2'd2);
    checkOutput("t1_suc",  arb_mem_SUC, 1);
    applyStimulus();
    applyStimulus();
    checkOutput("t1_iok_wait", mem_icache_dataOK, 0);
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_A5;
    #1;
    checkOutput("t1_iok",  mem_icache_dataOK, 1);
    checkOutput("t1_idin", din_mem_icache, RDATA_A5);
    checkOutput("t1_dok",  mem_dcache_dataOK, 0);
    checkOutput("t1_ddin", din_mem_dcache, 0);
    applyStimulus();
    icache_mem_req = 1'b0; mem_arb_dataOK = 1'b0; mem_arb_rdata = '0; icache_mem_SUC = 1'b0;
    #1 checkOutput("t1_done", arb_mem_req, 0);
    applyStimulus();

    // Simultaneous requests: last grant was I, so D should now win the tie?
    // No: previous winner was I, so the tie goes to D. Check that first.
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_0080;
    dcache_mem_req = 1'b1; dcache_mem_we = 1'b1; addr_dcache_mem = 32'h0000_1000;
    dcache_mem_size = 2'd2; dout_dcache_mem = WDATA_D;
    applyStimulus();
    checkOutput("t2_tie_after_i", arb_mem_addr, 32'h0000_1000);
    checkOutput("t2_we_d", arb_mem_we, 1);
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_3C;
    #1 checkOutput("t2_dok0", mem_dcache_dataOK, 1);
    applyStimulus();
    dcache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    applyStimulus();
    checkOutput("t2_i_next", arb_mem_addr, 32'h1C00_0080);
    mem_arb_dataOK = 1'b1;
    applyStimulus();
    icache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;

    // Reset, then both request in the same cycle: Icache wins, Dcache follows.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_0040;
    dcache_mem_req = 1'b1;
    applyStimulus();
    checkOutput("t3_first_i", arb_mem_addr, 32'h1C00_0040);
    checkOutput("t3_first_we", arb_mem_we, 0);
    checkOutput("t3_first_wd", arb_mem_wdata, 0);
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_A5;
    #1;
    checkOutput("t3_iok", mem_icache_dataOK, 1);
    checkOutput("t3_dok", mem_dcache_dataOK, 0);
    applyStimulus();
    icache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    #1 checkOutput("t3_gap", arb_mem_req, 0);
    applyStimulus();
    checkOutput("t3_d_req",   arb_mem_req, 1);
    checkOutput("t3_d_addr",  arb_mem_addr, 32'h0000_1000);
    checkOutput("t3_d_we",    arb_mem_we, 1);
    checkOutput("t3_d_wdata", arb_mem_wdata, WDATA_D);
    // Dcache inputs wobble while busy; the memory side must not move.
    addr_dcache_mem = 32'h0000_2222; dout_dcache_mem = WDATA_X; dcache_mem_we = 1'b0;
    applyStimulus();
    checkOutput("t4_hold_addr",  arb_mem_addr, 32'h0000_1000);
    checkOutput("t4_hold_wdata", arb_mem_wdata, WDATA_D);
    checkOutput("t4_hold_we",    arb_mem_we, 1);
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_3C;
    #1;
    checkOutput("t4_dok",  mem_dcache_dataOK, 1);
    checkOutput("t4_ddin", din_mem_dcache, RDATA_3C);
    checkOutput("t4_iok",  mem_icache_dataOK, 0);
    checkOutput("t4_idin", din_mem_icache, 0);
    applyStimulus();
    dcache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    applyStimulus();
    // Third tie after a D grant goes to Icache.
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_00C0;
    dcache_mem_req = 1'b1; addr_dcache_mem = 32'h0000_3000;
    applyStimulus();
    checkOutput("t3_tie3", arb_mem_addr, 32'h1C00_00C0);
    mem_arb_dataOK = 1'b1;
    applyStimulus();
    icache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    applyStimulus();
    checkOutput("t3_tie3_d", arb_mem_addr, 32'h0000_3000);
    mem_arb_dataOK = 1'b1;
    applyStimulus();
    dcache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    applyStimulus();

    // Late req drop: Icache keeps req one cycle past its dataOK.
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_0100;
    applyStimulus();
    checkOutput("t5_req", arb_mem_req, 1);
    mem_arb_dataOK = 1'b1;
    applyStimulus();
    mem_arb_dataOK = 1'b0;
    #1 checkOutput("t5_idle", arb_mem_req, 0);
    applyStimulus();
    icache_mem_req = 1'b0;
    checkOutput("t5_no_regrant", arb_mem_req, 0);
    applyStimulus();
    checkOutput("t5_still_idle", arb_mem_req, 0);

    // Reset mid-transaction, then a normal Dcache read.
    icache_mem_req = 1'b1; addr_icache_mem = 32'h1C00_0200;
    applyStimulus();
    checkOutput("t6_busy", arb_mem_req, 1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0; icache_mem_req = 1'b0;
    checkOutput("t6_req",  arb_mem_req, 0);
    checkOutput("t6_addr", arb_mem_addr, 0);
    checkOutput("t6_suc",  arb_mem_SUC, 0);
    dcache_mem_req = 1'b1; dcache_mem_we = 1'b0; addr_dcache_mem = 32'h0000_2000;
    dout_dcache_mem = WDATA_X;
    applyStimulus();
    checkOutput("t6_d_req",  arb_mem_req, 1);
    checkOutput("t6_d_addr", arb_mem_addr, 32'h0000_2000);
    checkOutput("t6_d_we",   arb_mem_we, 0);
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_A5;
    #1 checkOutput("t6_dok", mem_dcache_dataOK, 1);
    applyStimulus();
    dcache_mem_req = 1'b0; mem_arb_dataOK = 1'b0;
    applyStimulus();

    // Stray completion while idle must not reach either cache.
    mem_arb_dataOK = 1'b1; mem_arb_rdata = RDATA_3C;
    #1;
    checkOutput("t7_iok",  mem_icache_dataOK, 0);
    checkOutput("t7_dok",  mem_dcache_dataOK, 0);
    checkOutput("t7_idin", din_mem_icache, 0);
    checkOutput("t7_ddin", din_mem_dcache, 0);
    applyStimulus();
    mem_arb_dataOK = 1'b0;
    checkOutput("t7_req", arb_mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
